afifo_wr_ctrl: RTL and testbench

- Write-side controller of the async FIFO, in the write clock domain.
- Owns the binary write pointer and drives it to the pointer clock-crossing stage (binary→gray→sync→binary) toward the read domain.
- Consumes the read pointer already crossed into this domain.
- Generates RAM write address/enable, ready handshake, fill level, full and almost-full flags.

---
 rtl/afifo_pkg.sv | 27 ++
 rtl/afifo_wr_ctrl_if.sv | 23 ++
 rtl/afifo_level.sv | 25 ++
 rtl/afifo_wr_ctrl.sv | 85 ++++++++
 tb/tb_afifo_wr_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared helpers for the async FIFO read and write controllers:
// pointer width, depth, and the modular pointer difference.
package afifo_pkg;

   typedef struct packed {
      logic at_depth;
      logic ge_thr;
   } level_flags_t;

   function automatic int ptr_w(input int awidth);
      return awidth + 1;
   endfunction

   function automatic int depth(input int awidth);
      return 1 << awidth;
   endfunction

   // (a - b) modulo 2**w; operands are zero-extended pointers.
   function automatic logic [31:0] mod_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
      logic [31:0] mask;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/afifo_wr_ctrl_if.sv
// Producer / RAM write-port handshake bundle of the async FIFO write side.
interface afifo_wr_ctrl_if #(
   parameter int AWIDTH = 4
);
   logic              wr_req;
   logic              wr_rdy;
   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;

   modport master (
      output wr_req,
      input  wr_rdy,
      input  wr_en,
      input  wr_addr
   );

   modport slave (
      input  wr_req,
      output wr_rdy,
      output wr_en,
      output wr_addr
   );
endinterface

// File: rtl/afifo_level.sv
// Combinational FIFO fill level from two pointers plus threshold compares.
// Shared by the write-side and read-side controllers.
module afifo_level
   import afifo_pkg::*;
#(
   parameter int AWIDTH = 4,
   parameter int THR    = 2**AWIDTH - 2
) (
   input  logic [AWIDTH:0] ahead,
   input  logic [AWIDTH:0] behind,
   output logic [AWIDTH:0] level,
   output level_flags_t    flags
);
   localparam int PW = ptr_w(AWIDTH);
   localparam logic [AWIDTH:0] DEPTH_P = PW'(depth(AWIDTH));
   localparam logic [AWIDTH:0] THR_P   = PW'(THR);

   assign level = PW'(mod_diff(32'(ahead), 32'(behind), PW));

   always_comb begin
      flags          = '0;
      flags.at_depth = (level == DEPTH_P);
      flags.ge_thr   = (level >= THR_P);
   end
endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: owns the binary write pointer,
// fill level and full/afull flags. Optional check: AFIFO_WR_ERR_CHECK_EN.
module afifo_wr_ctrl
   import afifo_pkg::*;
#(
   parameter int AWIDTH    = 4,
   parameter int AFULL_THR = 2**AWIDTH - 2
) (
   input  logic            clk,
   input  logic            rst_n,
   afifo_wr_ctrl_if.slave  wr_bus,
   output logic [AWIDTH:0] wptr,
   input  logic [AWIDTH:0] rptr_sync,
   output logic [AWIDTH:0] used,
   output logic            full,
   output logic            afull,
   output logic            err
);
   logic            wr_rdy_q;
   logic            accept;
   logic [AWIDTH:0] wptr_next;
   logic [AWIDTH:0] used_next;
   level_flags_t    flags_next;

   assign accept         = wr_bus.wr_req & wr_rdy_q;
   assign wr_bus.wr_rdy  = wr_rdy_q;
   assign wr_bus.wr_en   = accept;
   assign wr_bus.wr_addr = wptr[AWIDTH-1:0];

   // Gray crossing downstream relies on wptr moving by at most +1 per clock.
   assign wptr_next = wptr + {{AWIDTH{1'b0}}, accept};

   afifo_level #(
      .AWIDTH (AWIDTH),
      .THR    (AFULL_THR)
   ) u_level (
      .ahead  (wptr_next),
      .behind (rptr_sync),
      .level  (used_next),
      .flags  (flags_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr     <= '0;
         used     <= '0;
         full     <= 1'b0;
         afull    <= 1'b0;
         wr_rdy_q <= 1'b0;
      end else begin
         wptr     <= wptr_next;
         used     <= used_next;
         full     <= flags_next.at_depth;
         afull    <= flags_next.ge_thr;
         wr_rdy_q <= !flags_next.at_depth;
      end
   end

`ifdef AFIFO_WR_ERR_CHECK_EN
   localparam logic [AWIDTH:0] DEPTH_P = (AWIDTH + 1)'(depth(AWIDTH));

   logic [AWIDTH:0] rptr_prev;
   logic [AWIDTH:0] rptr_step;
   logic            err_q;

   assign rptr_step = rptr_sync - rptr_prev;

   // The read side is reset alongside us, so its pointer restarts at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr_prev <= '0;
         err_q     <= 1'b0;
      end else begin
         rptr_prev <= rptr_sync;
         if ((used_next > DEPTH_P) || (rptr_step > {{AWIDTH{1'b0}}, 1'b1}))
            err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed vector bench for afifo_wr_ctrl at AWIDTH=2, DEPTH=4, AFULL_THR=3.
module tb_afifo_wr_ctrl;
   localparam int AW = 2;

   typedef struct {
      logic       rst_n;
      logic       req;
      logic [2:0] rptr;
      logic       en;
      logic [1:0] addr;
      logic [2:0] wptr;
      logic [2:0] used;
      logic       full;
      logic       afull;
      logic       rdy;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic [AW:0]   wptr;
   logic [AW:0]   rptr_sync;
   logic [AW:0]   used;
   logic          full;
   logic          afull;
   logic          err;

   int n_vec  = 0;
   int n_fail = 0;

   afifo_wr_ctrl_if #(.AWIDTH(AW)) bus ();

   afifo_wr_ctrl #(
      .AWIDTH    (AW),
      .AFULL_THR (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_bus    (bus.slave),
      .wptr      (wptr),
      .rptr_sync (rptr_sync),
      .used      (used),
      .full      (full),
      .afull     (afull),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic q, input logic [2:0] p,
                               input logic e, input logic [1:0] a,
                               input logic [2:0] w, input logic [2:0] u,
                               input logic f, input logic af, input logic rd);
      vec_t v;
      v.rst_n = r; v.req = q; v.rptr = p; v.en = e; v.addr = a;
      v.wptr = w; v.used = u; v.full = f; v.afull = af; v.rdy = rd;
      return v;
   endfunction

   task automatic cyc(input logic r, input logic q, input logic [2:0] p);
      rst_n = r; bus.wr_req = q; rptr_sync = p;
      @(posedge clk); #1;
   endtask

   vec_t vecs[$];

   initial begin
      // reset held with wr_req=1, then release
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,0, 0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,0, 0,0, 0,0,0,0,1));
      // fill: six requests, four accepts
      vecs.push_back(mk(1,1,0, 1,0, 1,1,0,0,1));
      vecs.push_back(mk(1,1,0, 1,1, 2,2,0,0,1));
      vecs.push_back(mk(1,1,0, 1,2, 3,3,0,1,1));
      vecs.push_back(mk(1,1,0, 1,3, 4,4,1,1,0));
      vecs.push_back(mk(1,1,0, 0,0, 4,4,1,1,0));
      vecs.push_back(mk(1,1,0, 0,0, 4,4,1,1,0));
      // drain one from full, refill
      vecs.push_back(mk(1,0,1, 0,0, 4,3,0,1,1));
      vecs.push_back(mk(1,1,1, 1,0, 5,4,1,1,0));
      // read advance with request at full: no accept this cycle
      vecs.push_back(mk(1,1,2, 0,1, 5,3,0,1,1));
      vecs.push_back(mk(1,1,2, 1,1, 6,4,1,1,0));
      // drain to used=2
      vecs.push_back(mk(1,0,3, 0,2, 6,3,0,1,1));
      vecs.push_back(mk(1,0,4, 0,2, 6,2,0,0,1));
      // ten writes with read trailing by two: pointer wraps 7->0
      vecs.push_back(mk(1,1,5, 1,2, 7,2,0,0,1));
      vecs.push_back(mk(1,1,6, 1,3, 0,2,0,0,1));
      vecs.push_back(mk(1,1,7, 1,0, 1,2,0,0,1));
      vecs.push_back(mk(1,1,0, 1,1, 2,2,0,0,1));
      vecs.push_back(mk(1,1,1, 1,2, 3,2,0,0,1));
      vecs.push_back(mk(1,1,2, 1,3, 4,2,0,0,1));
      vecs.push_back(mk(1,1,3, 1,0, 5,2,0,0,1));
      vecs.push_back(mk(1,1,4, 1,1, 6,2,0,0,1));
      vecs.push_back(mk(1,1,5, 1,2, 7,2,0,0,1));
      vecs.push_back(mk(1,1,6, 1,3, 0,2,0,0,1));
      // reset mid-operation
      vecs.push_back(mk(0,1,0, 1,0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0, 0,0, 0,0,0,0,1));

      rst_n = 1'b0; bus.wr_req = 1'b0; rptr_sync = '0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         rst_n = vecs[i].rst_n; bus.wr_req = vecs[i].req; rptr_sync = vecs[i].rptr;
         @(negedge clk);
         chk("wr_en",   i, 32'(bus.wr_en),   32'(vecs[i].en));
         chk("wr_addr", i, 32'(bus.wr_addr), 32'(vecs[i].addr));
         @(posedge clk); #1;
         chk("wptr",    i, 32'(wptr),        32'(vecs[i].wptr));
         chk("used",    i, 32'(used),        32'(vecs[i].used));
         chk("full",    i, 32'(full),        32'(vecs[i].full));
         chk("afull",   i, 32'(afull),       32'(vecs[i].afull));
         chk("wr_rdy",  i, 32'(bus.wr_rdy),  32'(vecs[i].rdy));
         chk("err",     i, 32'(err),         32'd0);
         n_vec++;
      end

`ifdef AFIFO_WR_ERR_CHECK_EN
      // over-depth: read pointer passes an empty write pointer
      cyc(0,0,0); cyc(1,0,0);
      chk("err_idle", 100, 32'(err), 32'd0); n_vec++;
      cyc(1,0,1);
      chk("err_overdepth", 101, 32'(err), 32'd1);
      chk("used_overdepth", 101, 32'(used), 32'd7); n_vec++;
      cyc(0,0,0);
      chk("err_reset", 102, 32'(err), 32'd0); n_vec++;
      // read pointer numerically ahead of write pointer is still a legal level
      cyc(1,1,0); cyc(1,1,0);
      chk("wptr_one", 103, 32'(wptr), 32'd1); n_vec++;
      cyc(1,0,6);
      chk("used_wrapped", 104, 32'(used), 32'd3); n_vec++;
      cyc(0,0,0);
      // jump of +3 in the read pointer with a legal level
      cyc(1,0,0);
      for (int i = 0; i < 4; i++) cyc(1,1,0);
      chk("err_full", 105, 32'(err), 32'd0);
      chk("used_full", 105, 32'(used), 32'd4); n_vec++;
      cyc(1,0,3);
      chk("err_jump", 106, 32'(err), 32'd1);
      chk("used_jump", 106, 32'(used), 32'd1); n_vec++;
      cyc(1,0,3);
      chk("err_sticky", 107, 32'(err), 32'd1); n_vec++;
      cyc(0,0,0);
      chk("err_cleared", 108, 32'(err), 32'd0); n_vec++;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
